// File: rtl/msi_l1_cache_ctrl.sv
// Fully associative L1 cache controller with MSI coherence.
// Each line holds state (00 empty, 01 I, 10 S, 11 M), tag and one data word.
// Ports:
//   Clock, Reset                      - clock, asynchronous active-high reset
//   ReqValid/ReqWrite/ReqAddr/ReqData - processor request; ReqReady high only in IDLE
//   RspValid/RspData/RspHit           - one-cycle processor response
//   DirReq*/DirAck/DirAckData         - directory request (00 WB, 01 RdMiss, 10 WrMiss, 11 Upg) and ack
//   SnpValid/SnpType/SnpAddr          - snoop (01 Fetch, 10 Inv, 11 FetchInv)
//   SnpAck/SnpHasData/SnpData         - registered snoop reply, one cycle after SnpValid
module msi_l1_cache_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int LINES  = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              ReqReady,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic              RspHit,
  output logic              DirReqValid,
  output logic [1:0]        DirReqType,
  output logic [ADDR_W-1:0] DirReqAddr,
  output logic [DATA_W-1:0] DirReqData,
  input  logic              DirAck,
  input  logic [DATA_W-1:0] DirAckData,
  input  logic              SnpValid,
  input  logic [1:0]        SnpType,
  input  logic [ADDR_W-1:0] SnpAddr,
  output logic              SnpAck,
  output logic              SnpHasData,
  output logic [DATA_W-1:0] SnpData
);
  localparam int IW = $clog2(LINES);

  typedef enum logic [2:0] {ST_IDLE, ST_WB, ST_MISS, ST_UPG, ST_RESP} fsm_t;
  typedef enum logic [1:0] {LS_EMPTY = 2'b00, LS_INV = 2'b01, LS_SHR = 2'b10, LS_MOD = 2'b11} line_t;
  typedef enum logic [1:0] {DR_WB = 2'b00, DR_RDMISS = 2'b01, DR_WRMISS = 2'b10, DR_UPG = 2'b11} dir_t;
  typedef enum logic [1:0] {SN_NONE = 2'b00, SN_FETCH = 2'b01, SN_INV = 2'b10, SN_FINV = 2'b11} snp_t;

  fsm_t              state_q, state_d;
  line_t             st_q [LINES];
  line_t             st_post [LINES];
  line_t             st_n [LINES];
  logic [ADDR_W-1:0] tag_q [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [IW-1:0]     rr_q, rr_d, idx_q, idx_d;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;
  logic              accept;

  logic              snp_hit, snp_has_d;
  logic [IW-1:0]     snp_idx;
  logic [DATA_W-1:0] snp_data_d;
  logic              req_hit, victim_free, victim_dirty;
  logic [IW-1:0]     hit_idx, victim;

  logic              wr_en;
  logic [IW-1:0]     wr_idx;
  line_t             wr_st;
  logic [ADDR_W-1:0] wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic              rsp_valid_d, rsp_hit_d, dir_valid_d;
  logic [DATA_W-1:0] rsp_data_d, dir_data_d;
  logic [1:0]        dir_type_d;
  logic [ADDR_W-1:0] dir_addr_d;

  // Snoop effect is resolved first; the local lookup below sees st_post.
  always_comb begin
    snp_hit    = 1'b0;
    snp_idx    = '0;
    snp_has_d  = 1'b0;
    snp_data_d = '0;
    for (int unsigned i = 0; i < LINES; i++)
      if (!snp_hit && tag_q[i] == SnpAddr && (st_q[i] == LS_SHR || st_q[i] == LS_MOD)) begin
        snp_hit = 1'b1;
        snp_idx = IW'(i);
      end
    st_post = st_q;
    if (SnpValid && snp_hit) begin
      if (st_q[snp_idx] == LS_MOD) begin
        if (SnpType == SN_FETCH || SnpType == SN_FINV) begin
          snp_has_d  = 1'b1;
          snp_data_d = data_q[snp_idx];
        end
        if (SnpType == SN_FETCH) st_post[snp_idx] = LS_SHR;
        else if (SnpType != SN_NONE) st_post[snp_idx] = LS_INV;
      end else if (SnpType == SN_INV || SnpType == SN_FINV) begin
        st_post[snp_idx] = LS_INV;
      end
    end

    req_hit     = 1'b0;
    hit_idx     = '0;
    victim_free = 1'b0;
    victim      = rr_q;
    for (int unsigned i = 0; i < LINES; i++) begin
      if (!req_hit && tag_q[i] == ReqAddr && (st_post[i] == LS_SHR || st_post[i] == LS_MOD)) begin
        req_hit = 1'b1;
        hit_idx = IW'(i);
      end
      if (!victim_free && (st_post[i] == LS_EMPTY || st_post[i] == LS_INV)) begin
        victim_free = 1'b1;
        victim      = IW'(i);
      end
    end
    victim_dirty = (st_post[victim] == LS_MOD);
  end

  assign accept = ReqValid && ReqReady && state_q == ST_IDLE;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    wr_en       = 1'b0;
    wr_idx      = idx_q;
    wr_st       = LS_EMPTY;
    wr_tag      = '0;
    wr_data     = '0;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    rsp_data_d  = RspData;
    dir_type_d  = DirReqType;
    dir_addr_d  = DirReqAddr;
    dir_data_d  = DirReqData;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        if (req_hit) begin
          idx_d = hit_idx;
          if (!ReqWrite || st_post[hit_idx] == LS_MOD) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_hit_d   = 1'b1;
            rsp_data_d  = ReqWrite ? ReqData : data_q[hit_idx];
            if (ReqWrite) begin
              wr_en = 1'b1; wr_idx = hit_idx; wr_st = LS_MOD; wr_tag = ReqAddr; wr_data = ReqData;
            end
          end else begin
            state_d    = ST_UPG;
            dir_type_d = DR_UPG;
            dir_addr_d = ReqAddr;
            dir_data_d = ReqData;
          end
        end else begin
          idx_d = victim;
          if (!victim_free) rr_d = (rr_q == IW'(LINES - 1)) ? '0 : rr_q + 1'b1;
          if (victim_dirty) begin
            state_d    = ST_WB;
            dir_type_d = DR_WB;
            dir_addr_d = tag_q[victim];
            dir_data_d = data_q[victim];
          end else begin
            state_d    = ST_MISS;
            dir_type_d = ReqWrite ? DR_WRMISS : DR_RDMISS;
            dir_addr_d = ReqAddr;
            dir_data_d = ReqData;
            // Silently drop a clean shared victim so it no longer answers snoops.
            if (st_post[victim] == LS_SHR) begin
              wr_en = 1'b1; wr_idx = victim; wr_st = LS_INV; wr_tag = tag_q[victim]; wr_data = data_q[victim];
            end
          end
        end
      end
      ST_WB: if (DirAck) begin
        wr_en      = 1'b1; wr_st = LS_INV; wr_tag = tag_q[idx_q]; wr_data = data_q[idx_q];
        state_d    = ST_MISS;
        dir_type_d = req_write_q ? DR_WRMISS : DR_RDMISS;
        dir_addr_d = req_addr_q;
        dir_data_d = req_data_q;
      end
      ST_MISS: if (DirAck) begin
        wr_en       = 1'b1;
        wr_st       = req_write_q ? LS_MOD : LS_SHR;
        wr_tag      = req_addr_q;
        wr_data     = req_write_q ? req_data_q : DirAckData;
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = wr_data;
      end
      // An ack always completes as a write fill, so an upgrade that lost its
      // S copy to a snoop in the same cycle needs no special case.
      ST_UPG: if (DirAck) begin
        wr_en       = 1'b1; wr_st = LS_MOD; wr_tag = req_addr_q; wr_data = req_data_q;
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = req_data_q;
      end else if (st_post[idx_q] != LS_SHR) begin
        state_d    = ST_MISS;
        dir_type_d = DR_WRMISS;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    dir_valid_d = (state_d == ST_WB || state_d == ST_MISS || state_d == ST_UPG);
    st_n = st_post;
    if (wr_en) st_n[wr_idx] = wr_st;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      idx_q       <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      for (int unsigned i = 0; i < LINES; i++) begin
        st_q[i]   <= LS_EMPTY;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      ReqReady    <= 1'b0;
      RspValid    <= 1'b0;
      RspHit      <= 1'b0;
      RspData     <= '0;
      DirReqValid <= 1'b0;
      DirReqType  <= '0;
      DirReqAddr  <= '0;
      DirReqData  <= '0;
      SnpAck      <= 1'b0;
      SnpHasData  <= 1'b0;
      SnpData     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      if (accept) begin
        req_write_q <= ReqWrite;
        req_addr_q  <= ReqAddr;
        req_data_q  <= ReqData;
      end
      st_q <= st_n;
      if (wr_en) begin
        tag_q[wr_idx]  <= wr_tag;
        data_q[wr_idx] <= wr_data;
      end
      ReqReady    <= (state_d == ST_IDLE);
      RspValid    <= rsp_valid_d;
      RspHit      <= rsp_hit_d;
      RspData     <= rsp_data_d;
      DirReqValid <= dir_valid_d;
      DirReqType  <= dir_type_d;
      DirReqAddr  <= dir_addr_d;
      DirReqData  <= dir_data_d;
      SnpAck      <= SnpValid;
      SnpHasData  <= snp_has_d;
      SnpData     <= snp_data_d;
    end
  end
endmodule

// File: tb/tb_msi_l1_cache_ctrl.sv
// Directed self-checking bench for msi_l1_cache_ctrl (defaults: 4-bit addr/data, 2 lines).
module tb_msi_l1_cache_ctrl;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       ReqValid = 1'b0, ReqWrite = 1'b0;
  logic [3:0] ReqAddr = '0, ReqData = '0;
  logic       ReqReady, RspValid, RspHit;
  logic [3:0] RspData;
  logic       DirReqValid;
  logic [1:0] DirReqType;
  logic [3:0] DirReqAddr, DirReqData;
  logic       DirAck = 1'b0;
  logic [3:0] DirAckData = '0;
  logic       SnpValid = 1'b0;
  logic [1:0] SnpType = '0;
  logic [3:0] SnpAddr = '0;
  logic       SnpAck, SnpHasData;
  logic [3:0] SnpData;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  msi_l1_cache_ctrl #(.ADDR_W(4), .DATA_W(4), .LINES(2)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqReady(ReqReady),
    .RspValid(RspValid), .RspData(RspData), .RspHit(RspHit),
    .DirReqValid(DirReqValid), .DirReqType(DirReqType), .DirReqAddr(DirReqAddr), .DirReqData(DirReqData),
    .DirAck(DirAck), .DirAckData(DirAckData),
    .SnpValid(SnpValid), .SnpType(SnpType), .SnpAddr(SnpAddr),
    .SnpAck(SnpAck), .SnpHasData(SnpHasData), .SnpData(SnpData)
  );

  always #5 Clock = ~Clock;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] d);
    ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqData = d;
    tick();
    ReqValid = 1'b0;
  endtask

  task automatic ack(input logic [3:0] d);
    DirAck = 1'b1; DirAckData = d;
    tick();
    DirAck = 1'b0;
  endtask

  task automatic snoop(input logic [1:0] t, input logic [3:0] a);
    SnpValid = 1'b1; SnpType = t; SnpAddr = a;
    tick();
    SnpValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    expect_eq("rst_ready", ReqReady, 0);
    expect_eq("rst_outs", {RspValid, RspHit, RspData, DirReqValid, DirReqType, DirReqAddr, DirReqData,
                           SnpAck, SnpHasData, SnpData}, 0);
    Reset = 1'b0;
    tick();
    expect_eq("ready_after_rst", ReqReady, 1);

    // Cold read miss on 1, filled with 2.
    issue(1'b0, 4'h1, 4'h0);
    expect_eq("rdmiss_req", {DirReqValid, DirReqType, DirReqAddr}, {1'b1, 2'b01, 4'h1});
    expect_eq("rdmiss_notready", ReqReady, 0);
    tick();
    expect_eq("rdmiss_stable", {DirReqValid, DirReqType, DirReqAddr}, {1'b1, 2'b01, 4'h1});
    ack(4'h2);
    expect_eq("rdmiss_rsp", {RspValid, RspHit, RspData, DirReqValid}, {1'b1, 1'b0, 4'h2, 1'b0});
    expect_eq("rdmiss_line0", dut.st_q[0], 2'b10);
    tick();
    expect_eq("rsp_pulse", {RspValid, ReqReady}, {1'b0, 1'b1});

    // Read hit.
    issue(1'b0, 4'h1, 4'h0);
    expect_eq("rdhit_rsp", {RspValid, RspHit, RspData, DirReqValid}, {1'b1, 1'b1, 4'h2, 1'b0});
    tick();

    // Write to shared line -> upgrade.
    issue(1'b1, 4'h1, 4'h9);
    expect_eq("upg_req", {DirReqValid, DirReqType, DirReqAddr}, {1'b1, 2'b11, 4'h1});
    ack(4'h0);
    expect_eq("upg_rsp", {RspValid, RspHit, RspData}, {1'b1, 1'b0, 4'h9});
    expect_eq("upg_line0", dut.st_q[0], 2'b11);
    tick();
    snoop(2'b01, 4'h1);
    expect_eq("fetch_m", {SnpAck, SnpHasData, SnpData}, {1'b1, 1'b1, 4'h9});
    expect_eq("fetch_line0", dut.st_q[0], 2'b10);
    tick();
    expect_eq("snpack_pulse", SnpAck, 0);

    // Write miss to 2 into free line 1.
    issue(1'b1, 4'h2, 4'h5);
    expect_eq("wrmiss_req", {DirReqValid, DirReqType, DirReqAddr}, {1'b1, 2'b10, 4'h2});
    ack(4'hF);
    expect_eq("wrmiss_rsp", {RspValid, RspHit, RspData}, {1'b1, 1'b0, 4'h5});
    expect_eq("wrmiss_line1", dut.st_q[1], 2'b11);
    tick();
    issue(1'b1, 4'h1, 4'h7);
    ack(4'h0);
    tick();
    // Write hit in M.
    issue(1'b1, 4'h1, 4'h8);
    expect_eq("wrhit_rsp", {RspValid, RspHit, RspData, DirReqValid}, {1'b1, 1'b1, 4'h8, 1'b0});
    tick();

    // Both lines M: read 3 evicts line 0 by round robin.
    expect_eq("rr_before", dut.rr_q, 0);
    issue(1'b0, 4'h3, 4'h0);
    expect_eq("wb_req", {DirReqValid, DirReqType, DirReqAddr, DirReqData}, {1'b1, 2'b00, 4'h1, 4'h8});
    expect_eq("rr_after", dut.rr_q, 1);
    ack(4'h0);
    expect_eq("wb_then_miss", {DirReqValid, DirReqType, DirReqAddr}, {1'b1, 2'b01, 4'h3});
    expect_eq("wb_line0_inv", dut.st_q[0], 2'b01);
    ack(4'h4);
    expect_eq("wb_fill_rsp", {RspValid, RspHit, RspData}, {1'b1, 1'b0, 4'h4});
    tick();

    // Line 1 (addr 2) to S, then lose the upgrade to a FetchInvalidate.
    snoop(2'b01, 4'h2);
    expect_eq("fetch_l1", {SnpAck, SnpHasData, SnpData}, {1'b1, 1'b1, 4'h5});
    tick();
    issue(1'b1, 4'h2, 4'h6);
    expect_eq("upg2_req", {DirReqValid, DirReqType, DirReqAddr}, {1'b1, 2'b11, 4'h2});
    snoop(2'b11, 4'h2);
    expect_eq("finv_s", {SnpAck, SnpHasData}, {1'b1, 1'b0});
    expect_eq("finv_line1", dut.st_q[1], 2'b01);
    expect_eq("upg_resend", {DirReqValid, DirReqType, DirReqAddr}, {1'b1, 2'b10, 4'h2});
    ack(4'h0);
    expect_eq("upg_lost_rsp", {RspValid, RspHit, RspData}, {1'b1, 1'b0, 4'h6});
    expect_eq("upg_lost_line1", dut.st_q[1], 2'b11);
    tick();

    // Snoop miss, then invalidate of S line 0.
    snoop(2'b01, 4'hF);
    expect_eq("snp_miss", {SnpAck, SnpHasData, SnpData}, {1'b1, 1'b0, 4'h0});
    tick();
    snoop(2'b10, 4'h3);
    expect_eq("inv_line0", dut.st_q[0], 2'b01);
    tick();

    // Same-cycle FetchInvalidate and read of addr 2: read sees the invalidated line.
    SnpValid = 1'b1; SnpType = 2'b11; SnpAddr = 4'h2;
    issue(1'b0, 4'h2, 4'h0);
    SnpValid = 1'b0;
    expect_eq("coll_snp", {SnpAck, SnpHasData, SnpData}, {1'b1, 1'b1, 4'h6});
    expect_eq("coll_miss", {DirReqValid, DirReqType, DirReqAddr}, {1'b1, 2'b01, 4'h2});
    ack(4'hA);
    expect_eq("coll_rsp", {RspValid, RspHit, RspData}, {1'b1, 1'b0, 4'hA});
    expect_eq("coll_line0", dut.st_q[0], 2'b10);
    tick();

    // Reset during MISS.
    issue(1'b0, 4'h9, 4'h0);
    expect_eq("pre_rst_miss", {DirReqValid, DirReqAddr}, {1'b1, 4'h9});
    #2 Reset = 1'b1;
    #1;
    expect_eq("midrst_outs", {ReqReady, RspValid, RspHit, RspData, DirReqValid, DirReqType, DirReqAddr,
                              DirReqData, SnpAck, SnpHasData, SnpData}, 0);
    expect_eq("midrst_lines", {dut.st_q[0], dut.st_q[1]}, 0);
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_eq("postrst_nodir", {DirReqValid, RspValid}, 0);
    end
    expect_eq("postrst_ready", ReqReady, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
